ysyx_22040125_mem_arbiter: RTL

Two-requester arbiter that shares the core's single memory port between instruction fetch (IF) and the MEM stage's data access (loads and stores). It sits between the fetch/data-RAM interfaces of the pipeline and one external memory port that accepts one request at a time and returns a response after a variable delay. Data accesses win by default. A starvation counter guarantees IF forward progress. At most one transaction is outstanding.

---
 rtl/ysyx_22040125_mem_arbiter.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ysyx_22040125_mem_arbiter.sv
// Shares one memory port between instruction fetch and data access, one transaction in flight.
// Data wins by default; a starvation counter forces an IF grant after STARVE_LIMIT data grants.
module ysyx_22040125_mem_arbiter #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [63:0] if_addr,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_wen,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  input  logic [7:0]  d_wmask,
  output logic        d_gnt,
  output logic        d_rvalid,
  output logic [63:0] d_rdata,
  output logic        mem_req,
  output logic        mem_wen,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  output logic [7:0]  mem_wmask,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_t;

  state_t     state, state_nxt;
  logic [3:0] starve_cnt;
  logic       lane_sel;
  logic       d_wen_q;
  logic       if_win, d_win, hs;
  logic       unused_addr_bits;

  assign unused_addr_bits = ^{if_addr[1:0], d_addr[2:0]};

  assign if_win = if_req & (~d_req | (starve_cnt == LIMIT));
  assign d_win  = d_req & ~if_win;
  assign hs     = (state == IDLE) & (if_req | d_req) & mem_ready;

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (hs) state_nxt = if_win ? WAIT_IF : WAIT_D;
      WAIT_IF: if (mem_rvalid) state_nxt = IDLE;
      WAIT_D:  if (mem_rvalid) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Fairness counter, fetch lane and store flag are captured at the grant handshake
  always_ff @(posedge clk) begin
    if (!rst) begin
      starve_cnt <= 4'd0;
      lane_sel   <= 1'b0;
      d_wen_q    <= 1'b0;
    end else if (hs) begin
      if (if_win) begin
        starve_cnt <= 4'd0;
        lane_sel   <= if_addr[2];
      end else begin
        d_wen_q <= d_wen;
        if (if_req && starve_cnt != LIMIT) starve_cnt <= starve_cnt + 4'd1;
      end
    end
  end

  // Everything is forced low while reset is held so nothing leaks to memory or the pipeline
  always_comb begin
    mem_req   = 1'b0;
    mem_wen   = 1'b0;
    mem_addr  = 64'd0;
    mem_wdata = 64'd0;
    mem_wmask = 8'h00;
    if_gnt    = 1'b0;
    d_gnt     = 1'b0;
    if_rvalid = 1'b0;
    if_rdata  = 32'd0;
    d_rvalid  = 1'b0;
    d_rdata   = 64'd0;
    if (rst) begin
      case (state)
        IDLE: begin
          mem_req = if_req | d_req;
          if (if_win) begin
            mem_addr = {if_addr[63:3], 3'b000};
            if_gnt   = mem_ready;
          end else if (d_win) begin
            mem_addr = {d_addr[63:3], 3'b000};
            mem_wen  = d_wen;
            if (d_wen) begin
              mem_wdata = d_wdata;
              mem_wmask = d_wmask;
            end
            d_gnt = mem_ready;
          end
        end
        WAIT_IF: if (mem_rvalid) begin
          if_rvalid = 1'b1;
          if_rdata  = lane_sel ? mem_rdata[63:32] : mem_rdata[31:0];
        end
        WAIT_D: if (mem_rvalid) begin
          d_rvalid = 1'b1;
          d_rdata  = d_wen_q ? 64'd0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule
